// File: rtl/bs_mul_if.sv
// Request/grant/result bundle between two requesters and the shared
// bit-serial multiplier.
interface bs_mul_if #(
  parameter int WIDTH = 8
);
  logic [1:0]         i_req;
  logic [WIDTH-1:0]   i_a0;
  logic [WIDTH-1:0]   i_b0;
  logic [WIDTH-1:0]   i_a1;
  logic [WIDTH-1:0]   i_b1;
  logic [1:0]         i_ack;
  logic [1:0]         o_gnt;
  logic [1:0]         o_valid;
  logic [2*WIDTH-1:0] o_result;
  logic               o_busy;

  modport master (
    output i_req, i_a0, i_b0, i_a1, i_b1, i_ack,
    input  o_gnt, o_valid, o_result, o_busy
  );

  modport slave (
    input  i_req, i_a0, i_b0, i_a1, i_b1, i_ack,
    output o_gnt, o_valid, o_result, o_busy
  );
endinterface

// File: rtl/bs_mul_arbiter.sv
// Shared WIDTH x WIDTH unsigned shift-add multiplier, one multiplier bit per
// clock, serving two requesters through a round-robin arbiter.
module bs_mul_arbiter #(
  parameter int WIDTH = 8
) (
  input logic     i_clk,
  input logic     i_rst,
  bs_mul_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic               last_q;
  logic               owner_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [PW-1:0]      acc_q;
  logic [PW-1:0]      acc_d;
  logic [1:0]         gnt_q;
  logic [1:0]         valid_q;
  logic [PW-1:0]      result_q;
  logic               busy_q;
  logic               win_s;

  // Round-robin winner: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    win_s = 1'b0;
    case (bus.i_req)
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
      2'b11:   win_s = ~last_q;
      default: win_s = 1'b0;
    endcase
  end

  // Partial-product accumulation for the current multiplier bit.
  always_comb begin
    acc_d = acc_q;
    if (b_sh_q[0]) begin
      acc_d = acc_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
    end else begin
      acc_d = acc_q;
    end
  end

  // Arbitration / calculation / hold FSM with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      gnt_q    <= 2'b00;
      valid_q  <= 2'b00;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 2'b00;
          if (bus.i_req != 2'b00) begin
            a_q     <= win_s ? bus.i_a1 : bus.i_a0;
            b_sh_q  <= win_s ? bus.i_b1 : bus.i_b0;
            owner_q <= win_s;
            acc_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= win_s ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
          end
        end
        CALC: begin
          gnt_q  <= 2'b00;
          acc_q  <= acc_d;
          b_sh_q <= b_sh_q >> 1;
          cnt_q  <= cnt_q + CNT_W'(1);
          // Fixed WIDTH-cycle latency: no early exit on zero operands.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_q <= acc_d;
            valid_q  <= owner_q ? 2'b10 : 2'b01;
            state_q  <= DONE;
          end else begin
            state_q  <= CALC;
          end
        end
        DONE: begin
          gnt_q <= 2'b00;
          if (bus.i_ack[owner_q]) begin
            valid_q <= 2'b00;
            last_q  <= owner_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          gnt_q   <= 2'b00;
          valid_q <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_gnt    = gnt_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_busy   = busy_q;
endmodule

// File: doc/bs_mul_arbiter.md
# bs_mul_arbiter

Shared bit-serial multiply unit that serves two requesters through a round-robin arbiter. It sits beside the bit_serial datapath so that separate instruction streams, such as the y·d and x·(1−d) terms, can use one shift-add multiplier instead of two. Each accepted request computes an unsigned WIDTH×WIDTH product, one multiplier bit per clock. The result is held until the owning requester acknowledges it.

## Interface
- WIDTH, 8, operand width in bits; product is 2·WIDTH bits.

- i_clk  input  1  single clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_req  input  2  request per requester; held high with stable operands until granted.
- i_a0, i_b0  input  WIDTH  multiplicand and multiplier, requester 0.
- i_a1, i_b1  input  WIDTH  multiplicand and multiplier, requester 1.
- i_ack  input  2  result acknowledge per requester.
- o_gnt  output  2  one-hot, one-cycle pulse: request accepted and operands captured.
- o_valid  output  2  one-hot: o_result is valid for that requester.
- o_result  output  2·WIDTH  unsigned product.
- o_busy  output  1  high whenever the unit is not IDLE.

## Operation
- States:
  - IDLE: o_busy=0; o_gnt and o_valid are 0.
  - CALC: o_busy=1.
  - DONE: o_busy=1.
- Round-robin pointer `last` (1 bit) holds the most recently served requester. It resets to 1, so requester 0 wins the first tie.
- IDLE, when i_req≠0:
  - Winner is the single requester if only one is asserting.
  - If both assert, the winner is ~last.
  - Capture a and b of the winner into internal registers; owner←winner; acc←0; cnt←0.
  - o_gnt[winner]←1 for exactly one cycle; next state is CALC.
- CALC, each cycle:
  - If b_sh[0]=1, acc←acc+(a zero-extended to 2·WIDTH, shifted left by cnt).
  - Then b_sh←b_sh>>1 and cnt←cnt+1.
  - Arithmetic is unsigned, 2·WIDTH wide, and never overflows (max (2^WIDTH−1)²).
- On the CALC cycle with cnt=WIDTH−1:
  - o_result←final acc, including that cycle's partial product.
  - o_valid[owner]←1; next state is DONE.
  - CALC always lasts exactly WIDTH cycles, independent of operand values; zero operands get no early exit.
- DONE:
  - Hold o_result and o_valid[owner].
  - When i_ack[owner]=1 is sampled: o_valid←0, last←owner, next state is IDLE.
  - i_ack of the non-owner is ignored.
  - o_result keeps its value after ack until the next completion overwrites it.
- Requests arriving in CALC or DONE are not sampled; they wait, still asserted, until IDLE.
- i_req deasserting before grant withdraws the request. No latching takes place.

## Timing
- Reset (i_rst high at an edge) puts every state and output at its reset value, including mid-CALC or DONE; any in-flight result is discarded.
  - o_gnt=0, o_valid=0, o_result=0, o_busy=0.
  - State IDLE, last=1, cnt=0, acc=0.
- Grant: i_req sampled high at edge E0 in IDLE → o_gnt high during the cycle after E0; operands are captured at E0.
- Result: o_valid rises at edge E0+WIDTH, i.e. WIDTH cycles after o_gnt rises (8 for the default).
- Ack sampled at edge Ek → o_valid low and o_busy low after Ek; the earliest next grant follows edge Ek+1.
- Minimum per-operation period with ack held high is WIDTH+2 cycles.
- A requester must drop i_req in the cycle after o_gnt. If it is still high at the next IDLE, that counts as a new request.

## Test plan
- Reset: i_rst=1 for 2 cycles with i_req=2'b11 → o_gnt=0, o_valid=0, o_result=0, o_busy=0; no grant until i_rst=0.
- Single request: i_req=01, a0=13, b0=11 → o_gnt=01 one cycle after the request; o_valid=01 with o_result=143 exactly 8 cycles after o_gnt; i_ack=01 → o_valid=00, o_busy=0 next cycle.
- Tie and round robin:
  - i_req=11, a0=b0=255, a1=2, b1=3 → req0 served first with o_result=16'hFE01.
  - After ack, req1 is granted with o_result=6.
  - Raising both again → req0 wins (last=1).
- Wrong ack: in DONE for owner 0, i_ack=10 for 5 cycles → o_valid stays 01 and o_result stays stable; then i_ack=01 → release.
- Reset mid-operation: i_rst=1 on the 4th CALC cycle → all outputs 0 next cycle; no o_valid ever appears for that request; a fresh request is then served normally.
- Zero multiplier: a1=200, b1=0 → o_result=0 with o_valid still exactly 8 cycles after o_gnt; a0=0, b0=255 → 0, same latency.
